emu_host_transactor: RTL and testbench
======================================

Name: emu_host_transactor

Overview:
- Host-side initiator for the byte-wide co-emulation wrapper interface (Din_emu, Dout_emu, Addr_emu, load_emu, get_emu, clk_dut).
- Takes stimulus bytes from a host byte stream (UART/USB bridge) and writes them into the wrapper's stimulus array. Then pulses load_emu, generates one DUT clock, pulses get_emu, reads back the output-vector bytes and returns them on a host byte stream.
- Lives on the emulator FPGA between the host link and the DUT wrapper.

Parameters:
- NUM_STIM_ARRAY, 2, stimulus bytes per transaction.
- NUM_OUT_ARRAY, 3, output bytes per transaction.
- ADDR_W, 3, Addr_emu width; NUM_STIM_ARRAY and NUM_OUT_ARRAY must each be ≤ 2**ADDR_W.
- CLK_HI_CYC, 2, clk_emu cycles clk_dut is held high (≥1).
- CLK_LO_CYC, 2, clk_emu cycles clk_dut is held low after the high phase (≥1).

Ports:
- clk_emu  in  1  emulator clock; every output is registered on its rising edge.
- rst_n_emu  in  1  asynchronous active-low reset.
- rx_data  in  8  host stimulus byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted when rx_valid & rx_ready.
- tx_data  out  8  output byte to host.
- tx_valid  out  1  tx_data valid; held with data stable until accepted.
- tx_ready  in  1  host accepts tx_data.
- Din_emu  out  8  stimulus byte to the wrapper.
- Addr_emu  out  ADDR_W  wrapper array index.
- load_emu  out  1  one-cycle pulse; wrapper applies stimulus to DUT inputs.
- get_emu  out  1  one-cycle pulse; wrapper captures DUT outputs.
- Dout_emu  in  8  wrapper read data, registered one cycle after Addr_emu.
- clk_dut  out  1  generated DUT clock.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: rx_ready 0, tx_valid 0, tx_data 0, Din_emu 0, Addr_emu 0, load_emu 0, get_emu 0, clk_dut 0, busy 0. The FSM enters IDLE. rx_ready rises on the first clock after reset release.
- Wrapper contract: with load_emu=0 and get_emu=0, the wrapper writes Din_emu into stimIn[Addr_emu] on every edge. load_emu has priority over get_emu.
- FSM states: IDLE, WR, LOAD, DCLK_HI, DCLK_LO, GET, RD_ADDR, RD_WAIT, TX.
- IDLE/WR:
  - rx_ready=1.
  - Each accepted byte k (k=0..NUM_STIM_ARRAY-1) drives Din_emu=byte and Addr_emu=k from the accept edge; the wrapper stores it on the next edge.
  - Bytes may arrive back-to-back or with gaps.
  - The accept of byte NUM_STIM_ARRAY-1 moves the FSM to LOAD and drops rx_ready.
- LOAD: load_emu=1 for exactly one cycle, starting the edge after the last accept, so the last byte is written first.
- DCLK_HI: clk_dut=1 for CLK_HI_CYC cycles. DCLK_LO: clk_dut=0 for CLK_LO_CYC cycles.
- GET: get_emu=1 for one cycle.
- RD_ADDR/RD_WAIT/TX:
  - For j=0..NUM_OUT_ARRAY-1: drive Addr_emu=j and wait two edges (wrapper register plus sample).
  - Then present tx_data=Dout_emu with tx_valid=1.
  - Hold until tx_ready; the accept of byte j advances j.
  - The accept of the last byte returns the FSM to IDLE.
- Side effect during reads: the wrapper also writes Din_emu into stimIn[j]. This is harmless because every transaction rewrites all stimulus bytes before load.
- Default latency: last rx accept at edge E0 → load_emu high E1–E2 → clk_dut high E2–E4, low E4–E6 → get_emu high E6–E7 → Addr_emu=0 from E7 → tx_valid high from E9.
- rx bytes arriving outside IDLE/WR are not accepted (backpressure, no drop).
- Counters wrap only through explicit reset to 0 at the end of each phase. No overflow past the array sizes.
- Reset mid-operation: all outputs return asynchronously to their reset values and any partial transaction is discarded. clk_dut drops immediately. DUT state is reset only through the ap_rst bit carried in the stimulus.

Optional Feature:
- Macro: EMU_RUN_COUNT_EN.
- Defined:
  - The first accepted byte of each transaction is a run count N, and the stimulus bytes follow.
  - After LOAD, N full clk_dut periods are generated before GET.
  - N=0 skips DCLK_HI/DCLK_LO, giving a combinational peek.
- Undefined: exactly one clk_dut period per transaction and no header byte.

Decomposition:
- Package emu_pkg:
  - FSM state enum.
  - Default NUM_STIM_ARRAY, NUM_OUT_ARRAY and ADDR_W constants.
  - Byte typedef.
- Sub-module emu_dut_clkgen:
  - Inputs: start pulse, run count. Outputs: clk_dut and a done pulse.
  - Counts CLK_HI_CYC/CLK_LO_CYC phases.

Test Plan:
- Reset then send 0x03,0x5A:
  - Addr_emu/Din_emu show 0/0x03 then 1/0x5A on consecutive cycles.
  - load_emu pulses once at E1, clk_dut high exactly 2 cycles, get_emu pulses once at E6.
- Behavioural wrapper with vectOut={0x0F,0x34,0x12} → tx bytes 0x0F,0x34,0x12 in order, first tx_valid at E9.
- tx_ready low for 5 cycles on byte 1 → tx_valid and tx_data=0x34 held stable; no Addr_emu advance.
- rx_valid held high continuously across two transactions (4 bytes) → rx_ready=0 from LOAD through the last TX accept; second transaction bytes are written correctly.
- Assert rst_n_emu during DCLK_HI → clk_dut, busy and load_emu at 0 immediately. A following transaction with 0x00,0x11 completes normally.
- EMU_RUN_COUNT_EN defined: send N=3 → three clk_dut periods. Send N=0 → zero periods, get_emu 1 cycle after load_emu.

Source files
------------

// File: rtl/emu_pkg.sv
// Shared types and default sizing for the co-emulation host transactor.
// Holds the transactor FSM state encoding and the byte type used on every data path.
package emu_pkg;

   localparam int EMU_NUM_STIM_ARRAY = 2;
   localparam int EMU_NUM_OUT_ARRAY  = 3;
   localparam int EMU_ADDR_W         = 3;
   localparam int EMU_CLK_HI_CYC     = 2;
   localparam int EMU_CLK_LO_CYC     = 2;

   typedef logic [7:0] emu_byte_t;

   typedef enum logic [3:0] {
      IDLE,
      WR,
      LOAD,
      DCLK_HI,
      DCLK_LO,
      GET,
      RD_ADDR,
      RD_WAIT,
      TX
   } emu_state_t;

endpackage

// File: rtl/emu_dut_clkgen.sv
// Generates run_count full clk_dut periods (CLK_HI_CYC high, CLK_LO_CYC low) after a start pulse.
// phase_end marks the last cycle of each phase; done marks the last cycle of the final low phase.
module emu_dut_clkgen
   import emu_pkg::*;
#(
   parameter int CLK_HI_CYC = EMU_CLK_HI_CYC,
   parameter int CLK_LO_CYC = EMU_CLK_LO_CYC
) (
   input  logic       clk_emu,
   input  logic       rst_n_emu,
   input  logic       start,
   input  logic [7:0] run_count,
   output logic       clk_dut,
   output logic       phase_end,
   output logic       done
);

   localparam int MAX_CYC = (CLK_HI_CYC > CLK_LO_CYC) ? CLK_HI_CYC : CLK_LO_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   logic             active;
   logic             hi;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lim;
   emu_byte_t        periods_left;

   assign lim       = hi ? CNT_W'(CLK_HI_CYC - 1) : CNT_W'(CLK_LO_CYC - 1);
   assign phase_end = active && (cnt == lim);
   assign done      = phase_end && !hi && (periods_left == 8'd1);

   // NOTE: the async reset clears clk_dut at once, so a mid-period reset never leaves the DUT clock high.
   always_ff @(posedge clk_emu or negedge rst_n_emu) begin
      if (!rst_n_emu) begin
         active       <= 1'b0;
         hi           <= 1'b0;
         cnt          <= '0;
         periods_left <= '0;
         clk_dut      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here, so every register samples the pre-edge values of the others.
         clk_dut <= active && hi;
         if (start) begin
            active       <= (run_count != 8'd0);
            hi           <= 1'b1;
            cnt          <= '0;
            periods_left <= run_count;
         end else if (active) begin
            if (cnt == lim) begin
               cnt <= '0;
               if (hi) begin
                  hi <= 1'b0;
               end else if (periods_left == 8'd1) begin
                  active <= 1'b0;
               end else begin
                  hi           <= 1'b1;
                  periods_left <= periods_left - 8'd1;
               end
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/emu_host_transactor.sv
// Host-side initiator for the byte-wide co-emulation wrapper: writes stimulus, loads, clocks, gets, reads back.
// Optional macro EMU_RUN_COUNT_EN: first byte of each transaction is the clk_dut period count (0 = peek).
module emu_host_transactor
   import emu_pkg::*;
#(
   parameter int NUM_STIM_ARRAY = EMU_NUM_STIM_ARRAY,
   parameter int NUM_OUT_ARRAY  = EMU_NUM_OUT_ARRAY,
   parameter int ADDR_W         = EMU_ADDR_W,
   parameter int CLK_HI_CYC     = EMU_CLK_HI_CYC,
   parameter int CLK_LO_CYC     = EMU_CLK_LO_CYC
) (
   input  logic              clk_emu,
   input  logic              rst_n_emu,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [7:0]        Din_emu,
   output logic [ADDR_W-1:0] Addr_emu,
   output logic              load_emu,
   output logic              get_emu,
   input  logic [7:0]        Dout_emu,
   output logic              clk_dut,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_STIM = ADDR_W'(NUM_STIM_ARRAY - 1);
   localparam logic [ADDR_W-1:0] LAST_OUT  = ADDR_W'(NUM_OUT_ARRAY - 1);

   emu_state_t        state, state_next;
   logic [ADDR_W-1:0] stim_idx, d_stim_idx;
   logic [ADDR_W-1:0] out_idx, d_out_idx;
   logic [ADDR_W-1:0] d_addr;
   emu_byte_t         d_din, d_tx_data;
   logic              d_tx_valid;
   logic              write_stim;
   logic              clk_start;
   logic              clk_phase_end;
   logic              clk_done;
   logic              rx_acc, tx_acc;
   emu_byte_t         run_count;

`ifdef EMU_RUN_COUNT_EN
   emu_byte_t         d_run_count;
`else
   assign run_count = 8'd1;
`endif

   assign rx_acc = rx_valid && rx_ready;
   assign tx_acc = tx_valid && tx_ready;

   // NOTE: every variable gets a default before the case, so no path can infer a latch.
   always_comb begin
      state_next = state;
      d_stim_idx = stim_idx;
      d_out_idx  = out_idx;
      d_addr     = Addr_emu;
      d_din      = Din_emu;
      d_tx_data  = tx_data;
      d_tx_valid = tx_valid;
      write_stim = 1'b0;
      clk_start  = 1'b0;
`ifdef EMU_RUN_COUNT_EN
      d_run_count = run_count;
`endif
      case (state)
         IDLE, WR: begin
            if (rx_acc) begin
`ifdef EMU_RUN_COUNT_EN
               if (state == IDLE) begin
                  d_run_count = rx_data;
                  state_next  = WR;
               end else begin
                  write_stim = 1'b1;
               end
`else
               write_stim = 1'b1;
`endif
            end
            if (write_stim) begin
               d_din  = rx_data;
               d_addr = stim_idx;
               if (stim_idx == LAST_STIM) begin
                  d_stim_idx = '0;
                  state_next = LOAD;
               end else begin
                  d_stim_idx = stim_idx + ADDR_W'(1);
                  state_next = WR;
               end
            end
         end
         LOAD: begin
            // A zero run count goes straight to GET for a combinational peek.
            if (run_count == 8'd0) begin
               state_next = GET;
            end else begin
               clk_start  = 1'b1;
               state_next = DCLK_HI;
            end
         end
         DCLK_HI: begin
            if (clk_phase_end) state_next = DCLK_LO;
         end
         DCLK_LO: begin
            if (clk_done)           state_next = GET;
            else if (clk_phase_end) state_next = DCLK_HI;
         end
         GET: begin
            state_next = RD_ADDR;
         end
         RD_ADDR: begin
            d_addr     = out_idx;
            state_next = RD_WAIT;
         end
         RD_WAIT: begin
            state_next = TX;
         end
         TX: begin
            // Dout_emu is captured once and held until the host takes it.
            if (!tx_valid) begin
               d_tx_valid = 1'b1;
               d_tx_data  = Dout_emu;
            end else if (tx_acc) begin
               d_tx_valid = 1'b0;
               if (out_idx == LAST_OUT) begin
                  d_out_idx  = '0;
                  state_next = IDLE;
               end else begin
                  d_out_idx  = out_idx + ADDR_W'(1);
                  state_next = RD_ADDR;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_emu or negedge rst_n_emu) begin
      if (!rst_n_emu) begin
         state    <= IDLE;
         stim_idx <= '0;
         out_idx  <= '0;
         rx_ready <= 1'b0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         Din_emu  <= '0;
         Addr_emu <= '0;
         load_emu <= 1'b0;
         get_emu  <= 1'b0;
         busy     <= 1'b0;
`ifdef EMU_RUN_COUNT_EN
         run_count <= '0;
`endif
      end else begin
         state    <= state_next;
         stim_idx <= d_stim_idx;
         out_idx  <= d_out_idx;
         rx_ready <= (state_next == IDLE) || (state_next == WR);
         tx_valid <= d_tx_valid;
         tx_data  <= d_tx_data;
         Din_emu  <= d_din;
         Addr_emu <= d_addr;
         load_emu <= (state == LOAD);
         get_emu  <= (state == GET);
         busy     <= (state_next != IDLE);
`ifdef EMU_RUN_COUNT_EN
         run_count <= d_run_count;
`endif
      end
   end

   emu_dut_clkgen #(
      .CLK_HI_CYC (CLK_HI_CYC),
      .CLK_LO_CYC (CLK_LO_CYC)
   ) u_clkgen (
      .clk_emu   (clk_emu),
      .rst_n_emu (rst_n_emu),
      .start     (clk_start),
      .run_count (run_count),
      .clk_dut   (clk_dut),
      .phase_end (clk_phase_end),
      .done      (clk_done)
   );

endmodule

// File: tb/tb_emu_host_transactor.sv
// Self-checking bench for emu_host_transactor with a behavioural wrapper model and a tx-byte scoreboard.
// Wrapper outputs: {applied[0]^0x0C, applied[1]^0x6E, 0x11 + clk_dut rising edges since load}.
module tb_emu_host_transactor;

   localparam int HI = 2;
   localparam int LO = 2;

   logic       clk_emu = 1'b0;
   logic       rst_n_emu;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] Din_emu;
   logic [2:0] Addr_emu;
   logic       load_emu;
   logic       get_emu;
   logic [7:0] Dout_emu;
   logic       clk_dut;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q[$];

   emu_host_transactor dut (
      .clk_emu   (clk_emu),
      .rst_n_emu (rst_n_emu),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .Din_emu   (Din_emu),
      .Addr_emu  (Addr_emu),
      .load_emu  (load_emu),
      .get_emu   (get_emu),
      .Dout_emu  (Dout_emu),
      .clk_dut   (clk_dut),
      .busy      (busy)
   );

   always #5 clk_emu = ~clk_emu;

   // Behavioural wrapper: load has priority over get, otherwise Din is written at Addr.
   logic [7:0]  stim_in [8];
   logic [7:0]  applied [2];
   logic [7:0]  vect_out [3];
   logic [7:0]  per_cnt;
   logic        clk_dut_q;

   always @(posedge clk_emu) begin
      clk_dut_q <= clk_dut;
      if (clk_dut && !clk_dut_q) per_cnt <= per_cnt + 8'd1;
      if (load_emu) begin
         applied[0] <= stim_in[0];
         applied[1] <= stim_in[1];
         per_cnt    <= 8'd0;
      end else if (get_emu) begin
         vect_out[0] <= applied[0] ^ 8'h0C;
         vect_out[1] <= applied[1] ^ 8'h6E;
         vect_out[2] <= 8'h11 + per_cnt;
      end else begin
         stim_in[Addr_emu] <= Din_emu;
      end
      Dout_emu <= (Addr_emu < 3'd3) ? vect_out[Addr_emu[1:0]] : 8'h00;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_emu);
      #1;
   endtask

   task automatic push_txn(input logic [7:0] n, input logic [7:0] s0, input logic [7:0] s1);
      exp_q.push_back(s0 ^ 8'h0C);
      exp_q.push_back(s1 ^ 8'h6E);
      exp_q.push_back(8'h11 + n);
   endtask

   task automatic pop_exp(output logic [7:0] e);
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
   endtask

   // k < 0 marks a header byte, which is not written to the wrapper.
   task automatic send_byte(input logic [7:0] b, input int k);
      int t = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && t < 50) begin tick(); t++; end
      check("rx_ready_wait", rx_ready, 1);
      tick();
      if (k >= 0) begin
         check($sformatf("addr_wr%0d", k), Addr_emu, k);
         check($sformatf("din_wr%0d", k), Din_emu, b);
      end
      rx_valid = 1'b0;
   endtask

   task automatic recv(input int j, input int hold);
      int t = 0;
      logic [7:0] e;
      while (!tx_valid && t < 50) begin tick(); t++; end
      check($sformatf("tx_valid_wait%0d", j), tx_valid, 1);
      pop_exp(e);
      check($sformatf("tx_data%0d", j), tx_data, e);
      for (int h = 0; h < hold; h++) begin
         tick();
         check($sformatf("hold_valid%0d", h), tx_valid, 1);
         check($sformatf("hold_data%0d", h), tx_data, e);
         check($sformatf("hold_addr%0d", h), Addr_emu, j);
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      check($sformatf("tx_drop%0d", j), tx_valid, 0);
   endtask

   task automatic run_txn(input logic [7:0] n, input logic [7:0] s0, input logic [7:0] s1,
                          input int hold1);
      int cyc = 0, load_cyc = -1, get_cyc = -1, rises = 0, loads = 0, gets = 0, rdy_hi = 0;
      logic prev_clk;
      push_txn(n, s0, s1);
`ifdef EMU_RUN_COUNT_EN
      send_byte(n, -1);
`endif
      send_byte(s0, 0);
      send_byte(s1, 1);
      check("rx_ready_drop", rx_ready, 0);
      prev_clk = clk_dut;
      while (!tx_valid && cyc < 200) begin
         tick();
         cyc++;
         if (load_emu) begin loads++; if (load_cyc < 0) load_cyc = cyc; end
         if (get_emu)  begin gets++;  if (get_cyc < 0)  get_cyc = cyc;  end
         if (clk_dut && !prev_clk) rises++;
         if (rx_ready) rdy_hi++;
         prev_clk = clk_dut;
      end
      check("load_cycle", load_cyc, 1);
      check("load_width", loads, 1);
      check("get_width", gets, 1);
      check("dclk_periods", rises, n);
      check("get_after_load", get_cyc - load_cyc, (n == 0) ? 1 : 1 + n * (HI + LO));
      check("txv_after_get", cyc - get_cyc, 3);
      check("rx_ready_low", rdy_hi, 0);
      for (int j = 0; j < 3; j++) recv(j, (j == 1) ? hold1 : 0);
      check("idle_busy", busy, 0);
      check("idle_rx_ready", rx_ready, 1);
   endtask

   initial begin
      logic [7:0] rxb[$];
      logic [7:0] e;
      int idx, got, viol, t, tx_at_b2, nb;
      logic acc_rx, acc_tx;

      rst_n_emu = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      tx_ready  = 1'b0;
      #12;
      check("rst_rx_ready", rx_ready, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_din", Din_emu, 0);
      check("rst_addr", Addr_emu, 0);
      check("rst_load", load_emu, 0);
      check("rst_get", get_emu, 0);
      check("rst_clk_dut", clk_dut, 0);
      check("rst_busy", busy, 0);
      #10;
      rst_n_emu = 1'b1;
      check("rx_ready_pre_edge", rx_ready, 0);
      tick();
      check("rx_ready_first_edge", rx_ready, 1);

      // Directed transaction with a 5-cycle host stall on byte 1.
      run_txn(8'd1, 8'h03, 8'h5A, 5);

      // rx_valid held high across two back-to-back transactions.
`ifdef EMU_RUN_COUNT_EN
      rxb = '{8'd1, 8'h21, 8'h42, 8'd1, 8'h9C, 8'h07};
`else
      rxb = '{8'h21, 8'h42, 8'h9C, 8'h07};
`endif
      push_txn(8'd1, 8'h21, 8'h42);
      push_txn(8'd1, 8'h9C, 8'h07);
      nb = rxb.size();
      idx = 0; got = 0; viol = 0; t = 0; tx_at_b2 = -1;
      tx_ready = 1'b1;
      rx_valid = 1'b1;
      rx_data  = rxb[0];
      while (got < 6 && t < 400) begin
         acc_rx = rx_valid && rx_ready;
         acc_tx = tx_valid && tx_ready;
         if (rx_ready && (load_emu || get_emu || clk_dut || tx_valid)) viol++;
         if (acc_tx) begin
            pop_exp(e);
            check($sformatf("b2b_tx%0d", got), tx_data, e);
         end
         if (acc_rx && idx == nb / 2) tx_at_b2 = got;
         tick();
         t++;
         if (acc_rx) begin
            idx++;
            if (idx < nb) rx_data = rxb[idx];
            else rx_valid = 1'b0;
         end
         if (acc_tx) got++;
      end
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      check("b2b_tx_count", got, 6);
      check("b2b_rx_count", idx, nb);
      check("b2b_second_start", tx_at_b2, 3);
      check("b2b_rx_ready_overlap", viol, 0);

      // Reset while clk_dut is high, then a clean transaction.
`ifdef EMU_RUN_COUNT_EN
      send_byte(8'd1, -1);
`endif
      send_byte(8'hAA, 0);
      send_byte(8'h55, 1);
      t = 0;
      while (!clk_dut && t < 20) begin tick(); t++; end
      check("mid_clk_dut_seen", clk_dut, 1);
      #2;
      rst_n_emu = 1'b0;
      #1;
      check("mid_rst_clk_dut", clk_dut, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_load", load_emu, 0);
      check("mid_rst_rx_ready", rx_ready, 0);
      tick();
      rst_n_emu = 1'b1;
      tick();
      check("post_rst_rx_ready", rx_ready, 1);
      run_txn(8'd1, 8'h00, 8'h11, 0);

`ifdef EMU_RUN_COUNT_EN
      run_txn(8'd3, 8'h7E, 8'hC3, 0);
      run_txn(8'd0, 8'h19, 8'h2B, 0);
`endif

      check("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
